// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 1024x768 @ 75 MHz display path.
// Defaults are overridable per instance through vga_timing_gen parameters.
package vga_timing_pkg;

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned CNT_MAX = 4096;

  localparam int unsigned H_ACTIVE_D = 1024;
  localparam int unsigned H_FP_D     = 24;
  localparam int unsigned H_SYNC_D   = 136;
  localparam int unsigned H_BP_D     = 144;
  localparam int unsigned H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int unsigned V_ACTIVE_D = 768;
  localparam int unsigned V_FP_D     = 3;
  localparam int unsigned V_SYNC_D   = 6;
  localparam int unsigned V_BP_D     = 29;
  localparam int unsigned V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int unsigned HS_START_D = H_ACTIVE_D + H_FP_D;
  localparam int unsigned HS_END_D   = HS_START_D + H_SYNC_D - 1;
  localparam int unsigned VS_START_D = V_ACTIVE_D + V_FP_D;
  localparam int unsigned VS_END_D   = VS_START_D + V_SYNC_D - 1;

  localparam logic        SYNC_POL_D = 1'b0;
  localparam logic        SYNC_ON_D  = SYNC_POL_D;
  localparam logic        SYNC_OFF_D = ~SYNC_POL_D;
  localparam int unsigned SYNC_DLY_D = 1;

  // Pin level for a sync that is (active=1) or is not (active=0) asserted.
  function automatic logic sync_level(input logic pol, input logic active);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register carrying {hsync, vsync} to match downstream pipeline latency.
module sync_delay_line #(
  parameter int unsigned     DEPTH   = 1,
  parameter int unsigned     W       = 2,
  parameter logic [W-1:0]    RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Display timing generator: h/v counters, video_on/frame_start decode, frame counter,
// and latency-matched sync pins.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FP     = H_FP_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_BP     = H_BP_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FP     = V_FP_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_BP     = V_BP_D,
  parameter logic        SYNC_POL = SYNC_POL_D,
  parameter int unsigned SYNC_DLY = SYNC_DLY_D
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [CNT_W-1:0]   pixel_column,
  output logic [CNT_W-1:0]   pixel_row,
  output logic               video_on,
  output logic               horiz_sync,
  output logic               vert_sync,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam logic        SYNC_OFF = sync_level(SYNC_POL, 1'b0);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX) begin : g_cnt_range_chk
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counter range");
  end
  if (SYNC_DLY > 4) begin : g_dly_range_chk
    $error("vga_timing_gen: SYNC_DLY must be 0..4");
  end

  logic [CNT_W-1:0]   r_col, r_row;
  logic               r_video_on, r_frame_start;
  logic [FRAME_W-1:0] r_frame_count;

  logic [CNT_W-1:0]   w_col_nxt, w_row_nxt;
  logic               w_col_last, w_row_last, w_frame_start_nxt;
  logic [1:0]         w_sync_nxt, w_sync_q;

  // Next counter position; all registered outputs are decoded from it so they share one clock.
  always_comb begin
    w_col_last        = (r_col == CNT_W'(H_TOTAL - 1));
    w_row_last        = (r_row == CNT_W'(V_TOTAL - 1));
    w_col_nxt         = w_col_last ? '0 : r_col + CNT_W'(1);
    w_row_nxt         = r_row;
    if (w_col_last) w_row_nxt = w_row_last ? '0 : r_row + CNT_W'(1);
    w_frame_start_nxt = (w_col_nxt == '0) && (w_row_nxt == '0);
    w_sync_nxt[1]     = sync_level(SYNC_POL, (w_col_nxt >= CNT_W'(HS_START)) &&
                                             (w_col_nxt <= CNT_W'(HS_END)));
    w_sync_nxt[0]     = sync_level(SYNC_POL, (w_row_nxt >= CNT_W'(VS_START)) &&
                                             (w_row_nxt <= CNT_W'(VS_END)));
  end

  // Counters sit at the last position in reset so the first edge lands on (0,0).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col         <= CNT_W'(H_TOTAL - 1);
      r_row         <= CNT_W'(V_TOTAL - 1);
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_video_on    <= (w_col_nxt < CNT_W'(H_ACTIVE)) && (w_row_nxt < CNT_W'(V_ACTIVE));
      r_frame_start <= w_frame_start_nxt;
      if (w_frame_start_nxt) r_frame_count <= r_frame_count + FRAME_W'(1);
    end
  end

  // One stage aligns syncs with the counters; SYNC_DLY more match the colorizer pipeline.
  sync_delay_line #(
    .DEPTH   (SYNC_DLY + 1),
    .W       (2),
    .RST_VAL ({SYNC_OFF, SYNC_OFF})
  ) u_sync_dly (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (w_sync_nxt),
    .o_q  (w_sync_q)
  );

  assign pixel_column = r_col;
  assign pixel_row    = r_row;
  assign video_on     = r_video_on;
  assign frame_start  = r_frame_start;
  assign frame_count  = r_frame_count;
  assign horiz_sync   = w_sync_q[1];
  assign vert_sync    = w_sync_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for line checks, two reduced-timing instances
// (28x16 total, sync windows col 18..21 / row 11..12) for frame, reset and wrap checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] d_col, d_row, s_col, s_row, p_col, p_row;
  logic        d_vid, d_hs, d_vs, d_fs, s_vid, s_hs, s_vs, s_fs, p_vid, p_hs, p_vs, p_fs;
  logic [15:0] d_fc, s_fc, p_fc;

  vga_timing_gen dut_d (
    .clk(clk), .rstn(rstn), .pixel_column(d_col), .pixel_row(d_row), .video_on(d_vid),
    .horiz_sync(d_hs), .vert_sync(d_vs), .frame_start(d_fs), .frame_count(d_fc));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(6), .V_ACTIVE(10), .V_FP(1), .V_SYNC(2),
    .V_BP(3), .SYNC_POL(1'b0), .SYNC_DLY(1)
  ) dut_s (
    .clk(clk), .rstn(rstn), .pixel_column(s_col), .pixel_row(s_row), .video_on(s_vid),
    .horiz_sync(s_hs), .vert_sync(s_vs), .frame_start(s_fs), .frame_count(s_fc));

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(6), .V_ACTIVE(10), .V_FP(1), .V_SYNC(2),
    .V_BP(3), .SYNC_POL(1'b1), .SYNC_DLY(0)
  ) dut_p (
    .clk(clk), .rstn(rstn), .pixel_column(p_col), .pixel_row(p_row), .video_on(p_vid),
    .horiz_sync(p_hs), .vert_sync(p_vs), .frame_start(p_fs), .frame_count(p_fc));

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int cnt_dhs = 0, cnt_shs = 0, cnt_svs = 0, cnt_phs = 0, cnt_pvs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the given edge number (edge 1 = first edge after reset release), sampling #1 after.
  task automatic run_to(input int target);
    while (edge_n < target) begin
      @(posedge clk); #1;
      edge_n++;
      if (edge_n <= 1328 && d_hs == 1'b0) cnt_dhs++;
      if (edge_n <= 448) begin
        if (s_hs == 1'b0) cnt_shs++;
        if (s_vs == 1'b0) cnt_svs++;
        if (p_hs == 1'b1) cnt_phs++;
        if (p_vs == 1'b1) cnt_pvs++;
      end
    end
  endtask

  task automatic chk_first_edges();
    run_to(1);
    chk("e1_d_col", d_col, 0);      chk("e1_d_row", d_row, 0);
    chk("e1_d_vid", d_vid, 1);      chk("e1_d_fs", d_fs, 1);
    chk("e1_d_fc", d_fc, 1);        chk("e1_s_col", s_col, 0);
    chk("e1_s_row", s_row, 0);      chk("e1_s_fs", s_fs, 1);
    chk("e1_s_fc", s_fc, 1);        chk("e1_p_fc", p_fc, 1);
    chk("e1_s_hs", s_hs, 1);        chk("e1_p_hs", p_hs, 0);
    run_to(2);
    chk("e2_d_fs", d_fs, 0);        chk("e2_d_col", d_col, 1);
    chk("e2_s_fs", s_fs, 0);        chk("e2_d_fc", d_fc, 1);
  endtask

  initial begin
    // Reset held 10 clocks
    repeat (10) @(posedge clk);
    #1;
    chk("rst_d_col", d_col, 1327);  chk("rst_d_row", d_row, 805);
    chk("rst_d_vid", d_vid, 0);     chk("rst_d_hs", d_hs, 1);
    chk("rst_d_vs", d_vs, 1);       chk("rst_d_fc", d_fc, 0);
    chk("rst_d_fs", d_fs, 0);       chk("rst_s_col", s_col, 27);
    chk("rst_s_row", s_row, 15);    chk("rst_p_hs", p_hs, 0);
    chk("rst_p_vs", p_vs, 0);

    @(negedge clk) rstn = 1'b1;
    edge_n = 0;
    chk_first_edges();

    // Small-timing line: active ends at col 16, hsync windows
    run_to(16);  chk("s_vid_c15", s_vid, 1);
    run_to(17);  chk("s_vid_c16", s_vid, 0);
    run_to(18);  chk("p_hs_c17", p_hs, 0);
    run_to(19);  chk("p_hs_c18", p_hs, 1);  chk("s_hs_c18", s_hs, 1);
    run_to(20);  chk("s_hs_c19", s_hs, 0);
    run_to(22);  chk("p_hs_c21", p_hs, 1);
    run_to(23);  chk("p_hs_c22", p_hs, 0);  chk("s_hs_c22", s_hs, 0);
    run_to(24);  chk("s_hs_c23", s_hs, 1);
    run_to(29);  chk("s_row_l1", s_row, 1); chk("s_col_l1", s_col, 0);
    // Vertical: last active row, vsync start/end
    run_to(268); chk("s_vid_r9", s_vid, 1);
    run_to(281); chk("s_vid_r10", s_vid, 0);
    run_to(308); chk("p_vs_r10", p_vs, 0);
    run_to(309); chk("p_vs_r11", p_vs, 1);  chk("s_vs_r11", s_vs, 1);
    run_to(310); chk("s_vs_r11d", s_vs, 0);
    run_to(364); chk("p_vs_r12e", p_vs, 1);
    run_to(365); chk("p_vs_r13", p_vs, 0);  chk("s_vs_r13", s_vs, 0);
    run_to(366); chk("s_vs_end", s_vs, 1);
    run_to(448); chk("s_fs_last", s_fs, 0); chk("s_fc_last", s_fc, 1);
    run_to(449);
    chk("s_fs_f2", s_fs, 1);  chk("s_fc_f2", s_fc, 2);
    chk("s_col_f2", s_col, 0); chk("s_row_f2", s_row, 0);
    chk("s_hs_cnt", cnt_shs, 64);  chk("s_vs_cnt", cnt_svs, 56);
    chk("p_hs_cnt", cnt_phs, 64);  chk("p_vs_cnt", cnt_pvs, 56);

    // Frame counter wrap 0xFFFF -> 0
    run_to(896); chk("s_fc_pre", s_fc, 2);
    force dut_s.r_frame_count = 16'hFFFF;
    #1;
    release dut_s.r_frame_count;
    run_to(897);
    chk("s_fc_wrap", s_fc, 0);  chk("s_fs_wrap", s_fs, 1);  chk("p_fc_f3", p_fc, 3);

    // Default-timing line
    run_to(1024); chk("d_vid_c1023", d_vid, 1);
    run_to(1025); chk("d_vid_c1024", d_vid, 0);
    run_to(1049); chk("d_col_1048", d_col, 1048); chk("d_hs_c1048", d_hs, 1);
    run_to(1050); chk("d_hs_c1049", d_hs, 0);
    run_to(1185); chk("d_hs_c1184", d_hs, 0);
    run_to(1186); chk("d_hs_c1185", d_hs, 1);
    run_to(1329);
    chk("d_col_l1", d_col, 0);  chk("d_row_l1", d_row, 1);
    chk("d_fs_l1", d_fs, 0);    chk("d_hs_cnt", cnt_dhs, 136);

    // Async reset mid-frame while both small syncs are asserted
    run_to(1672);
    chk("s_col_mid", s_col, 19); chk("s_row_mid", s_row, 11);
    chk("s_hs_mid", s_hs, 0);    chk("s_vs_mid", s_vs, 0);
    #2 rstn = 1'b0;
    #1;
    chk("mrst_s_col", s_col, 27); chk("mrst_s_row", s_row, 15);
    chk("mrst_s_hs", s_hs, 1);    chk("mrst_s_vs", s_vs, 1);
    chk("mrst_s_fc", s_fc, 0);    chk("mrst_s_vid", s_vid, 0);
    chk("mrst_d_col", d_col, 1327); chk("mrst_p_vs", p_vs, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    edge_n = 0;
    chk_first_edges();
    run_to(19); chk("rr_s_hs_c18", s_hs, 1); chk("rr_s_vs", s_vs, 1);
    run_to(20); chk("rr_s_hs_c19", s_hs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
